// File: rtl/ahb_lite_cordic_ctrl.sv
// ahb_lite_cordic_ctrl: AHB-Lite slave with posted operand buffer to the CORDIC core,
// result-FIFO reads with timeout, outstanding-op tracking, STATUS/CTRL registers and irq.
module ahb_lite_cordic_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] cordic_in_data,
    output logic        cordic_in_valid,
    input  logic        cordic_in_ready,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        irq
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_DONE, REG, ERR1, ERR2} state_t;
    state_t state, state_d;

    logic [CNT_W-1:0] outstanding;
    logic [TW-1:0] wcnt;
    logic [31:0] status;
    logic ovf, irq_en, reg_ctrl, reg_wr;
    logic acc, is_data, is_status, is_ctrl, illegal, inc, dec, timeout_hit, ctrl_wr;
    logic unused;

    assign acc       = HSEL && HREADY && HTRANS[1];
    assign is_data   = HADDR[ADDR_W-1:0] == ADDR_W'(0);
    assign is_status = HADDR[ADDR_W-1:0] == ADDR_W'(4);
    assign is_ctrl   = HADDR[ADDR_W-1:0] == ADDR_W'(8);
    // a DATA read with nothing queued and nothing in flight could never complete
    assign illegal   = !(is_data || is_status || is_ctrl) || HSIZE != 3'b010 ||
                       (is_data && !HWRITE && fifo_empty && outstanding == '0);
    assign inc         = cordic_in_valid && cordic_in_ready;
    assign dec         = fifo_rd_en && outstanding != '0;
    assign timeout_hit = (TIMEOUT != 0) && (wcnt == TW'(TIMEOUT - 1));
    assign ctrl_wr     = state == REG && reg_ctrl && reg_wr;
    assign irq         = irq_en && !fifo_empty;
    assign status      = {16'b0, 8'(outstanding), 4'b0, ovf, cordic_in_valid, fifo_empty, irq};
    assign unused      = ^{HADDR[31:ADDR_W], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else state <= state_d;
    end

    // a completing data phase may accept the next address phase directly
    always_comb begin
        state_d = state;
        if (HREADYOUT) state_d = !acc ? IDLE : illegal ? ERR1 : !is_data ? REG : HWRITE ? WR : RD;
        else if (state == RD) state_d = !fifo_empty ? RD_DONE : timeout_hit ? ERR1 : RD;
        else if (state == ERR1) state_d = ERR2;
    end

    always_comb begin
        HREADYOUT  = !(state == RD || state == ERR1 || (state == WR && cordic_in_valid));
        HRESP      = state == ERR1 || state == ERR2;
        fifo_rd_en = state == RD && !fifo_empty;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA          <= '0;
            cordic_in_valid <= 1'b0;
            cordic_in_data  <= '0;
            outstanding     <= '0;
            ovf             <= 1'b0;
            irq_en          <= 1'b0;
            reg_ctrl        <= 1'b0;
            reg_wr          <= 1'b0;
            wcnt            <= '0;
        end else begin
            wcnt <= state == RD ? wcnt + 1'b1 : '0;
            if (HREADYOUT && acc) begin
                reg_ctrl <= is_ctrl;
                reg_wr   <= HWRITE;
                if (!illegal && !HWRITE && !is_data) HRDATA <= is_ctrl ? {31'b0, irq_en} : status;
            end
            if (fifo_rd_en) HRDATA <= fifo_rd_data;
            if (state == WR && !cordic_in_valid) begin
                cordic_in_valid <= 1'b1;
                cordic_in_data  <= HWDATA;
            end else if (inc) cordic_in_valid <= 1'b0;
            if (ctrl_wr) irq_en <= HWDATA[0];
            if (inc && !dec && outstanding == '1) ovf <= 1'b1;
            else if (ctrl_wr && HWDATA[1]) ovf <= 1'b0;
            if (inc && !dec && outstanding != '1) outstanding <= outstanding + 1'b1;
            else if (dec && !inc) outstanding <= outstanding - 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_lite_cordic_ctrl.sv
// tb_ahb_lite_cordic_ctrl: randomized self-checking bench for the AHB-Lite CORDIC bridge,
// with a transaction-level model of the outstanding count, ovf, irq_en and FIFO occupancy.
module tb_ahb_lite_cordic_ctrl;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_BAD = 32'hC;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic [31:0] cordic_in_data;
    logic        cordic_in_valid, cordic_in_ready = 1'b0;
    logic        fifo_rd_en, fifo_empty = 1'b1, irq;
    logic [31:0] fifo_rd_data = '0;

    logic        push_req = 1'b0;
    logic [31:0] push_val = '0;
    logic [31:0] fq[$];
    logic [31:0] got[$];
    int pops = 0, valid_cycles = 0;
    int n_checks = 0, n_fail = 0;
    int exp_out = 0, exp_fifo = 0;
    logic exp_ovf = 1'b0, exp_irq_en = 1'b0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_lite_cordic_ctrl #(.ADDR_W(4), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .cordic_in_data(cordic_in_data), .cordic_in_valid(cordic_in_valid),
        .cordic_in_ready(cordic_in_ready), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .irq(irq));

    // show-ahead result FIFO and CORDIC-side observer
    always @(posedge HCLK) begin
        if (HRESETn && fifo_rd_en && fq.size() > 0) begin
            void'(fq.pop_front());
            pops <= pops + 1;
        end
        if (push_req) fq.push_back(push_val);
        fifo_empty   <= fq.size() == 0;
        fifo_rd_data <= fq.size() > 0 ? fq[0] : 32'h0;
        if (HRESETn && cordic_in_valid) valid_cycles <= valid_cycles + 1;
        if (HRESETn && cordic_in_valid && cordic_in_ready) got.push_back(cordic_in_data);
    end

    function automatic void m_deliver();
        if (exp_out == CNT_MAX) exp_ovf = 1'b1;
        else exp_out++;
    endfunction

    function automatic void m_pop();
        if (exp_out > 0) exp_out--;
        exp_fifo--;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'b0, 8'(exp_out), 4'b0, exp_ovf, 1'b0, exp_fifo == 0, exp_irq_en && exp_fifo != 0};
    endfunction

    task automatic settle();
        repeat (3) @(negedge HCLK);
    endtask

    task automatic push_fifo(input logic [31:0] v);
        @(negedge HCLK);
        push_req = 1'b1;
        push_val = v;
        @(negedge HCLK);
        push_req = 1'b0;
        exp_fifo++;
    endtask

    // single transfer; push_at = data-phase cycle in which the FIFO first shows data (-1 = never)
    task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input int push_at, input logic [31:0] pval,
                            output logic [31:0] rdata, output int errc, output int waits);
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size;
        push_req = push_at == 0;
        push_val = pval;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        errc = 0;
        waits = 0;
        forever begin
            if (HRESP) errc++;
            if (HREADYOUT || waits >= 200) break;
            push_req = push_at == waits + 1;
            waits++;
            @(negedge HCLK);
        end
        push_req = 1'b0;
        rdata = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int e, w;
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        n_checks++;
        if ({HREADYOUT, HRESP, cordic_in_valid, fifo_rd_en, irq} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 10000", {HREADYOUT, HRESP, cordic_in_valid, fifo_rd_en, irq});
        end
        n_checks++;
        if (HRDATA !== 32'h0 || cordic_in_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got HRDATA %h data %h expected 0", HRDATA, cordic_in_data);
        end
        HRESETn = 1'b1;
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status() || e !== 0 || w !== 0) begin
            n_fail++;
            $display("FAIL reset_status: got %h err %0d waits %0d expected %h", rd, e, w, m_status());
        end
    endtask

    task automatic test_write_single();
        logic [31:0] rd, d;
        int e, w, v0, g0;
        d = 32'h1234_5678;
        cordic_in_ready = 1'b1;
        v0 = valid_cycles;
        g0 = got.size();
        ahb_xfer(A_DATA, 1'b1, 3'b010, d, -1, 32'h0, rd, e, w);
        settle();
        m_deliver();
        n_checks++;
        if (w !== 0 || e !== 0) begin
            n_fail++;
            $display("FAIL wr_waits: got waits %0d err %0d expected 0/0", w, e);
        end
        n_checks++;
        if (valid_cycles - v0 !== 1) begin
            n_fail++;
            $display("FAIL wr_valid_len: got %0d expected 1", valid_cycles - v0);
        end
        n_checks++;
        if (got.size() !== g0 + 1 || got[got.size()-1] !== d) begin
            n_fail++;
            $display("FAIL wr_operand: got %h expected %h", got[got.size()-1], d);
        end
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL wr_status: got %h expected %h", rd, m_status());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        int n, w, g0;
        d1 = $urandom;
        d2 = $urandom;
        n = 4;
        g0 = got.size();
        cordic_in_ready = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = A_DATA; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
        @(negedge HCLK);
        HWDATA = d1;
        n_checks++;
        if (HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got HREADYOUT %b expected 1", HREADYOUT);
        end
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d2;
        w = 0;
        forever begin
            if (HREADYOUT || w >= 200) break;
            cordic_in_ready = w >= n;
            w++;
            @(negedge HCLK);
        end
        cordic_in_ready = 1'b1;
        settle();
        m_deliver();
        m_deliver();
        n_checks++;
        if (w !== n + 1) begin
            n_fail++;
            $display("FAIL b2b_waits: got %0d expected %0d", w, n + 1);
        end
        n_checks++;
        if (got.size() !== g0 + 2 || got[g0] !== d1 || got[g0+1] !== d2) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d ops expected %0d (%h,%h)", got.size() - g0, 2, d1, d2);
        end
    endtask

    task automatic test_read_data();
        logic [31:0] rd, v;
        int e, w, p0, d;
        for (int i = 0; i < 3; i++) begin
            v = i == 0 ? 32'h0000_CAFE : $urandom;
            d = i == 0 ? 3 : int'($urandom_range(0, 5));
            p0 = pops;
            ahb_xfer(A_DATA, 1'b0, 3'b010, 32'h0, d, v, rd, e, w);
            exp_fifo++;
            m_pop();
            n_checks++;
            if (w !== d + 1) begin
                n_fail++;
                $display("FAIL rd_waits[%0d]: got %0d expected %0d", i, w, d + 1);
            end
            n_checks++;
            if (rd !== v) begin
                n_fail++;
                $display("FAIL rd_data[%0d]: got %h expected %h", i, rd, v);
            end
            n_checks++;
            if (pops - p0 !== 1 || e !== 0) begin
                n_fail++;
                $display("FAIL rd_pop[%0d]: got pops %0d err %0d expected 1/0", i, pops - p0, e);
            end
        end
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL rd_status: got %h expected %h", rd, m_status());
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int e, w, p0, g0;
        p0 = pops;
        g0 = got.size();
        cordic_in_ready = 1'b1;
        ahb_xfer(A_DATA, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (e !== 2 || w !== 1 || pops !== p0) begin
            n_fail++;
            $display("FAIL err_empty_rd: got err %0d waits %0d pops %0d expected 2/1/0", e, w, pops - p0);
        end
        ahb_xfer(A_DATA, 1'b1, 3'b000, $urandom, -1, 32'h0, rd, e, w);
        settle();
        n_checks++;
        if (e !== 2 || w !== 1 || got.size() !== g0) begin
            n_fail++;
            $display("FAIL err_byte_wr: got err %0d waits %0d ops %0d expected 2/1/0", e, w, got.size() - g0);
        end
        ahb_xfer(A_BAD, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (e !== 2 || w !== 1) begin
            n_fail++;
            $display("FAIL err_unmapped: got err %0d waits %0d expected 2/1", e, w);
        end
        ahb_xfer(32'h14, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (e !== 0 || rd !== m_status()) begin
            n_fail++;
            $display("FAIL alias_status: got err %0d data %h expected 0/%h", e, rd, m_status());
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int e, w, p0;
        cordic_in_ready = 1'b1;
        ahb_xfer(A_DATA, 1'b1, 3'b010, $urandom, -1, 32'h0, rd, e, w);
        settle();
        m_deliver();
        p0 = pops;
        ahb_xfer(A_DATA, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (w !== TIMEOUT + 1 || e !== 2) begin
            n_fail++;
            $display("FAIL timeout: got waits %0d err %0d expected %0d/2", w, e, TIMEOUT + 1);
        end
        n_checks++;
        if (pops !== p0) begin
            n_fail++;
            $display("FAIL timeout_pop: got %0d pops expected 0", pops - p0);
        end
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL timeout_status: got %h expected %h", rd, m_status());
        end
    endtask

    task automatic test_ctrl_irq();
        logic [31:0] rd, v;
        int e, w;
        v = $urandom;
        ahb_xfer(A_CTRL, 1'b1, 3'b010, 32'h1, -1, 32'h0, rd, e, w);
        exp_irq_en = 1'b1;
        ahb_xfer(A_CTRL, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== 32'h1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_rd: got %h irq %b expected 00000001/0", rd, irq);
        end
        push_fifo(v);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL irq_status: got %h expected %h", rd, m_status());
        end
        ahb_xfer(A_DATA, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        m_pop();
        n_checks++;
        if (rd !== v || w !== 1) begin
            n_fail++;
            $display("FAIL irq_pop: got %h waits %0d expected %h/1", rd, w, v);
        end
        @(negedge HCLK);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr: got %b expected 0", irq);
        end
        ahb_xfer(A_CTRL, 1'b1, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        exp_irq_en = 1'b0;
    endtask

    task automatic test_ovf();
        logic [31:0] rd, s0;
        int e, w, bad;
        cordic_in_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < CNT_MAX + 1; i++) begin
            ahb_xfer(A_DATA, 1'b1, 3'b010, $urandom, -1, 32'h0, rd, e, w);
            if (w != 0 || e != 0) bad++;
            m_deliver();
        end
        settle();
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL ovf_writes: got %0d stalled writes expected 0", bad);
        end
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status() || rd[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %h expected %h", rd, m_status());
        end
        ahb_xfer(A_CTRL, 1'b1, 3'b010, 32'h2, -1, 32'h0, rd, e, w);
        exp_ovf = 1'b0;
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL ovf_clr: got %h expected %h", rd, m_status());
        end
        ahb_xfer(A_CTRL, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL ctrl_rd0: got %h expected 00000000", rd);
        end
        s0 = m_status();
        ahb_xfer(A_STAT, 1'b1, 3'b010, $urandom, -1, 32'h0, rd, e, w);
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== s0 || e !== 0) begin
            n_fail++;
            $display("FAIL status_wr_ignored: got %h err %0d expected %h/0", rd, e, s0);
        end
    endtask

    task automatic test_reset_mid_rd();
        logic [31:0] rd;
        int e, w, g0;
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        cordic_in_ready = 1'b0;
        ahb_xfer(A_DATA, 1'b1, 3'b010, $urandom | 32'h1, -1, 32'h0, rd, e, w);
        g0 = got.size();
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = A_DATA; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (2) @(negedge HCLK);
        n_checks++;
        if (HREADYOUT !== 1'b0 || cordic_in_valid !== 1'b1 || HRDATA === 32'h0) begin
            n_fail++;
            $display("FAIL pre_reset: got rdy %b valid %b HRDATA %h expected 0/1/nonzero", HREADYOUT, cordic_in_valid, HRDATA);
        end
        #2 HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({HREADYOUT, HRESP, cordic_in_valid, fifo_rd_en} !== 4'b1000 || HRDATA !== 32'h0 || cordic_in_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctl %b HRDATA %h data %h expected 1000/0/0",
                     {HREADYOUT, HRESP, cordic_in_valid, fifo_rd_en}, HRDATA, cordic_in_data);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        exp_out = 0;
        exp_ovf = 1'b0;
        exp_irq_en = 1'b0;
        cordic_in_ready = 1'b1;
        settle();
        ahb_xfer(A_STAT, 1'b0, 3'b010, 32'h0, -1, 32'h0, rd, e, w);
        n_checks++;
        if (rd !== m_status() || got.size() !== g0) begin
            n_fail++;
            $display("FAIL post_reset: got %h ops %0d expected %h/0", rd, got.size() - g0, m_status());
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_back_to_back();
        test_read_data();
        test_errors();
        test_timeout();
        test_ctrl_irq();
        test_ovf();
        test_reset_mid_rd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
